usbf_icb_mst: RTL and testbench

//  ICB initiator: turns single-word register requests from a local requester (test sequencer,

---
 rtl/usbf_icb_mst_if.sv | 48 ++++
 rtl/usbf_icb_mst.sv | 138 +++++++++++++
 tb/tb_usbf_icb_mst.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usbf_icb_mst_if.sv
`default_nettype none
// ============================================================================
//  Module   : usbf_icb_mst_if
//  Brief    : Request/done and ICB cmd/rsp signal bundle for usbf_icb_mst.
//             The master modport is the initiator side; the slave modport is
//             the requester plus ICB slave side.
//  Revision : 1.0  initial release
// ============================================================================
interface usbf_icb_mst_if;
    // Local requester side
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_read_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        done_valid_o;
    logic        done_err_o;
    logic [31:0] done_rdata_o;
    logic        stray_o;
    // ICB bus side
    logic        icb_cmd_valid_o;
    logic        icb_cmd_ready_i;
    logic [31:0] icb_cmd_addr_o;
    logic        icb_cmd_read_o;
    logic [31:0] icb_cmd_wdata_o;
    logic        icb_rsp_valid_i;
    logic        icb_rsp_ready_o;
    logic [31:0] icb_rsp_rdata_i;

    modport master (
        input  req_valid_i, req_read_i, req_addr_i, req_wdata_i,
        output req_ready_o, done_valid_o, done_err_o, done_rdata_o, stray_o,
        output icb_cmd_valid_o, icb_cmd_addr_o, icb_cmd_read_o, icb_cmd_wdata_o,
        input  icb_cmd_ready_i,
        input  icb_rsp_valid_i, icb_rsp_rdata_i,
        output icb_rsp_ready_o
    );

    modport slave (
        output req_valid_i, req_read_i, req_addr_i, req_wdata_i,
        input  req_ready_o, done_valid_o, done_err_o, done_rdata_o, stray_o,
        input  icb_cmd_valid_o, icb_cmd_addr_o, icb_cmd_read_o, icb_cmd_wdata_o,
        output icb_cmd_ready_i,
        output icb_rsp_valid_i, icb_rsp_rdata_i,
        input  icb_rsp_ready_o
    );
endinterface
`default_nettype wire

// File: rtl/usbf_icb_mst.sv
`default_nettype none
// ============================================================================
//  Module   : usbf_icb_mst
//  Brief    : Single-outstanding ICB initiator. Converts one-word register
//             requests into ICB cmd/rsp transactions, with a saturating wait
//             counter that turns a stuck command or missing response into an
//             error completion. Responses arriving while idle are dropped and
//             flagged as stray.
//  Revision : 1.0  initial release
// ============================================================================
module usbf_icb_mst #(
    parameter int TIMEOUT_W = 8
) (
    input  wire logic        hclk_i,
    input  wire logic        hrst_i,
    usbf_icb_mst_if.master   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_RSP  = 2'd2
    } state_t;

    localparam logic [TIMEOUT_W-1:0] C_CNT_MAX = {TIMEOUT_W{1'b1}};

    state_t               r_state;
    logic [TIMEOUT_W-1:0] r_cnt;
    logic                 r_req_ready;
    logic                 r_cmd_valid;
    logic                 r_rsp_ready;
    logic                 r_done_valid;
    logic                 r_done_err;
    logic [31:0]          r_done_rdata;
    logic                 r_stray;
    logic [31:0]          r_addr;
    logic [31:0]          r_wdata;
    logic                 r_read;

    // Handshake outputs are registered copies of the state decode, updated
    // together with every state transition.
    assign bus.req_ready_o     = r_req_ready;
    assign bus.icb_cmd_valid_o = r_cmd_valid;
    assign bus.icb_rsp_ready_o = r_rsp_ready;
    assign bus.icb_cmd_addr_o  = r_addr;
    assign bus.icb_cmd_wdata_o = r_wdata;
    assign bus.icb_cmd_read_o  = r_read;
    assign bus.done_valid_o    = r_done_valid;
    assign bus.done_err_o      = r_done_err;
    assign bus.done_rdata_o    = r_done_rdata;
    assign bus.stray_o         = r_stray;

    // Transaction FSM: IDLE accepts a request, CMD presents it on the bus,
    // RSP waits for the slave; both wait states share the timeout counter.
    always_ff @(posedge hclk_i or posedge hrst_i) begin
        if (hrst_i) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_req_ready  <= 1'b1;
            r_cmd_valid  <= 1'b0;
            r_rsp_ready  <= 1'b1;
            r_done_valid <= 1'b0;
            r_done_err   <= 1'b0;
            r_done_rdata <= 32'h0;
            r_stray      <= 1'b0;
            r_addr       <= 32'h0;
            r_wdata      <= 32'h0;
            r_read       <= 1'b0;
        end else begin
            // Completion and stray flags are single-cycle pulses.
            r_done_valid <= 1'b0;
            r_done_err   <= 1'b0;
            r_stray      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // rsp_ready is high here, so any response is consumed.
                    if (bus.icb_rsp_valid_i) begin
                        r_stray <= 1'b1;
                    end
                    if (bus.req_valid_i) begin
                        r_addr      <= bus.req_addr_i;
                        r_wdata     <= bus.req_wdata_i;
                        r_read      <= bus.req_read_i;
                        r_cnt       <= '0;
                        r_state     <= S_CMD;
                        r_req_ready <= 1'b0;
                        r_cmd_valid <= 1'b1;
                        r_rsp_ready <= 1'b0;
                    end
                end
                S_CMD: begin
                    if (bus.icb_cmd_ready_i) begin
                        r_cnt       <= '0;
                        r_state     <= S_RSP;
                        r_cmd_valid <= 1'b0;
                        r_rsp_ready <= 1'b1;
                    end else if (r_cnt == C_CNT_MAX) begin
                        r_state      <= S_IDLE;
                        r_done_valid <= 1'b1;
                        r_done_err   <= 1'b1;
                        r_req_ready  <= 1'b1;
                        r_cmd_valid  <= 1'b0;
                        r_rsp_ready  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RSP: begin
                    // A response checked first so it wins over a timeout
                    // occurring in the same cycle.
                    if (bus.icb_rsp_valid_i) begin
                        if (r_read) begin
                            r_done_rdata <= bus.icb_rsp_rdata_i;
                        end
                        r_state      <= S_IDLE;
                        r_done_valid <= 1'b1;
                        r_req_ready  <= 1'b1;
                    end else if (r_cnt == C_CNT_MAX) begin
                        r_state      <= S_IDLE;
                        r_done_valid <= 1'b1;
                        r_done_err   <= 1'b1;
                        r_req_ready  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                    r_cmd_valid <= 1'b0;
                    r_rsp_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_usbf_icb_mst.sv
`default_nettype none
// ============================================================================
//  Module   : tb_usbf_icb_mst
//  Brief    : Directed self-checking bench for usbf_icb_mst (TIMEOUT_W=4).
//             Inputs are driven and outputs observed at the falling edge, so
//             "cycle n" below is the clock period whose values are seen at
//             that falling edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_usbf_icb_mst;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    usbf_icb_mst_if bus ();

    usbf_icb_mst #(.TIMEOUT_W(4)) dut (
        .hclk_i (clk),
        .hrst_i (rst),
        .bus    (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic quiet();
        bus.req_valid_i     = 1'b0;
        bus.req_read_i      = 1'b0;
        bus.req_addr_i      = 32'h0;
        bus.req_wdata_i     = 32'h0;
        bus.icb_cmd_ready_i = 1'b0;
        bus.icb_rsp_valid_i = 1'b0;
        bus.icb_rsp_rdata_i = 32'h0;
    endtask

    task automatic test_reset();
        quiet();
        rst = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({bus.done_valid_o, bus.done_err_o, bus.stray_o, bus.icb_cmd_valid_o} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_flags got=%b want=0000",
                {bus.done_valid_o, bus.done_err_o, bus.stray_o, bus.icb_cmd_valid_o});
        end
        n_cmp++;
        if ({bus.req_ready_o, bus.icb_rsp_ready_o} !== 2'b11) begin
            n_bad++; $display("FAIL reset_ready got=%b want=11", {bus.req_ready_o, bus.icb_rsp_ready_o});
        end
        n_cmp++;
        if ({bus.done_rdata_o, bus.icb_cmd_addr_o, bus.icb_cmd_wdata_o, bus.icb_cmd_read_o} !== 97'h0) begin
            n_bad++; $display("FAIL reset_regs got rdata=%h addr=%h wdata=%h read=%b want zeros",
                bus.done_rdata_o, bus.icb_cmd_addr_o, bus.icb_cmd_wdata_o, bus.icb_cmd_read_o);
        end
        rst = 1'b0;
        tick();
    endtask

    // Write A=0x10, cmd accepted in cycle 1, response in cycle 3, done in cycle 4.
    task automatic test_write();
        bus.req_valid_i = 1'b1; bus.req_read_i = 1'b0;
        bus.req_addr_i = 32'h10; bus.req_wdata_i = 32'h5A5A5A5A;
        bus.icb_cmd_ready_i = 1'b1;
        tick();                                    // cycle 1
        bus.req_valid_i = 1'b0;
        n_cmp++;
        if ({bus.icb_cmd_valid_o, bus.icb_cmd_read_o, bus.icb_cmd_addr_o, bus.icb_cmd_wdata_o}
            !== {1'b1, 1'b0, 32'h10, 32'h5A5A5A5A}) begin
            n_bad++; $display("FAIL wr_cmd got v=%b r=%b a=%h d=%h want v=1 r=0 a=10 d=5a5a5a5a",
                bus.icb_cmd_valid_o, bus.icb_cmd_read_o, bus.icb_cmd_addr_o, bus.icb_cmd_wdata_o);
        end
        tick();                                    // cycle 2
        bus.icb_cmd_ready_i = 1'b0;
        n_cmp++;
        if ({bus.icb_cmd_valid_o, bus.icb_rsp_ready_o, bus.done_valid_o} !== 3'b010) begin
            n_bad++; $display("FAIL wr_rsp_wait got cv/rr/dv=%b want 010",
                {bus.icb_cmd_valid_o, bus.icb_rsp_ready_o, bus.done_valid_o});
        end
        tick();                                    // cycle 3
        bus.icb_rsp_valid_i = 1'b1; bus.icb_rsp_rdata_i = 32'h11111111;
        tick();                                    // cycle 4
        bus.icb_rsp_valid_i = 1'b0;
        n_cmp++;
        if ({bus.done_valid_o, bus.done_err_o, bus.req_ready_o} !== 3'b101) begin
            n_bad++; $display("FAIL wr_done got dv/de/rq=%b want 101",
                {bus.done_valid_o, bus.done_err_o, bus.req_ready_o});
        end
        n_cmp++;
        if (bus.done_rdata_o !== 32'h0) begin
            n_bad++; $display("FAIL wr_rdata_hold got=%h want=00000000", bus.done_rdata_o);
        end
        tick();                                    // cycle 5
        n_cmp++;
        if ({bus.done_valid_o, bus.done_err_o} !== 2'b00) begin
            n_bad++; $display("FAIL wr_done_pulse got=%b want=00", {bus.done_valid_o, bus.done_err_o});
        end
    endtask

    // Read A=0x04 at minimum latency, immediately followed by a write request.
    task automatic test_back_to_back();
        bus.req_valid_i = 1'b1; bus.req_read_i = 1'b1; bus.req_addr_i = 32'h04;
        bus.icb_cmd_ready_i = 1'b1;
        tick();                                    // cycle 1: cmd handshake
        bus.req_valid_i = 1'b0;
        n_cmp++;
        if ({bus.req_ready_o, bus.icb_cmd_read_o, bus.icb_cmd_addr_o} !== {1'b0, 1'b1, 32'h04}) begin
            n_bad++; $display("FAIL rd_cmd got rq=%b r=%b a=%h want rq=0 r=1 a=00000004",
                bus.req_ready_o, bus.icb_cmd_read_o, bus.icb_cmd_addr_o);
        end
        tick();                                    // cycle 2: response
        bus.icb_cmd_ready_i = 1'b0;
        bus.icb_rsp_valid_i = 1'b1; bus.icb_rsp_rdata_i = 32'hDEADBEEF;
        n_cmp++;
        if ({bus.req_ready_o, bus.icb_rsp_ready_o} !== 2'b01) begin
            n_bad++; $display("FAIL rd_rsp_cyc got rq/rr=%b want 01", {bus.req_ready_o, bus.icb_rsp_ready_o});
        end
        tick();                                    // cycle 3: done + next request
        bus.icb_rsp_valid_i = 1'b0;
        n_cmp++;
        if ({bus.done_valid_o, bus.done_err_o, bus.req_ready_o, bus.done_rdata_o}
            !== {3'b101, 32'hDEADBEEF}) begin
            n_bad++; $display("FAIL rd_done got dv/de/rq=%b rdata=%h want 101 deadbeef",
                {bus.done_valid_o, bus.done_err_o, bus.req_ready_o}, bus.done_rdata_o);
        end
        bus.req_valid_i = 1'b1; bus.req_read_i = 1'b0;
        bus.req_addr_i = 32'h20; bus.req_wdata_i = 32'hA5A5_0001;
        bus.icb_cmd_ready_i = 1'b1;
        tick();                                    // cycle 4
        bus.req_valid_i = 1'b0;
        n_cmp++;
        if ({bus.icb_cmd_valid_o, bus.icb_cmd_addr_o} !== {1'b1, 32'h20}) begin
            n_bad++; $display("FAIL b2b_cmd got v=%b a=%h want v=1 a=00000020",
                bus.icb_cmd_valid_o, bus.icb_cmd_addr_o);
        end
        tick();                                    // cycle 5
        bus.icb_cmd_ready_i = 1'b0;
        bus.icb_rsp_valid_i = 1'b1; bus.icb_rsp_rdata_i = 32'h22222222;
        tick();                                    // cycle 6
        bus.icb_rsp_valid_i = 1'b0;
        n_cmp++;
        if ({bus.done_valid_o, bus.done_rdata_o} !== {1'b1, 32'hDEADBEEF}) begin
            n_bad++; $display("FAIL b2b_done got dv=%b rdata=%h want 1 deadbeef",
                bus.done_valid_o, bus.done_rdata_o);
        end
        tick();
    endtask

    // Command held off for 5 cycles while req_valid stays high with new values.
    task automatic test_stall();
        bus.req_valid_i = 1'b1; bus.req_read_i = 1'b0;
        bus.req_addr_i = 32'h08; bus.req_wdata_i = 32'h12345678;
        tick();                                    // cycle 1
        bus.req_addr_i = 32'hFF; bus.req_wdata_i = 32'hFFFFFFFF; bus.req_read_i = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            if (i == 6) bus.icb_cmd_ready_i = 1'b1;
            n_cmp++;
            if ({bus.icb_cmd_valid_o, bus.req_ready_o, bus.icb_cmd_read_o, bus.icb_cmd_addr_o, bus.icb_cmd_wdata_o}
                !== {3'b100, 32'h08, 32'h12345678}) begin
                n_bad++; $display("FAIL stall_c%0d got v=%b rq=%b r=%b a=%h d=%h want 1 0 0 00000008 12345678",
                    i, bus.icb_cmd_valid_o, bus.req_ready_o, bus.icb_cmd_read_o,
                    bus.icb_cmd_addr_o, bus.icb_cmd_wdata_o);
            end
            tick();
        end
        // cycle 7: in RSP
        bus.req_valid_i = 1'b0; bus.icb_cmd_ready_i = 1'b0;
        bus.icb_rsp_valid_i = 1'b1;
        n_cmp++;
        if ({bus.icb_cmd_valid_o, bus.icb_rsp_ready_o} !== 2'b01) begin
            n_bad++; $display("FAIL stall_rsp got cv/rr=%b want 01", {bus.icb_cmd_valid_o, bus.icb_rsp_ready_o});
        end
        tick();                                    // cycle 8
        bus.icb_rsp_valid_i = 1'b0;
        n_cmp++;
        if ({bus.done_valid_o, bus.done_err_o} !== 2'b10) begin
            n_bad++; $display("FAIL stall_done got=%b want=10", {bus.done_valid_o, bus.done_err_o});
        end
        tick();
    endtask

    // Read, cmd handshake in cycle 1, slave silent: counter is 0 in cycle 2
    // and reaches 15 in cycle 17, so the error completion shows in cycle 18.
    // A late response in cycle 21 is then dropped as stray (seen in cycle 22).
    task automatic test_rsp_timeout();
        bus.req_valid_i = 1'b1; bus.req_read_i = 1'b1; bus.req_addr_i = 32'h30;
        bus.icb_cmd_ready_i = 1'b1;
        tick();                                    // cycle 1
        bus.req_valid_i = 1'b0;
        tick();                                    // cycle 2
        bus.icb_cmd_ready_i = 1'b0;
        for (int c = 2; c < 17; c++) tick();       // now cycle 17
        n_cmp++;
        if (bus.done_valid_o !== 1'b0) begin
            n_bad++; $display("FAIL to_early got=%b want=0", bus.done_valid_o);
        end
        tick();                                    // cycle 18
        n_cmp++;
        if ({bus.done_valid_o, bus.done_err_o, bus.req_ready_o, bus.done_rdata_o} !== {3'b111, 32'hDEADBEEF}) begin
            n_bad++; $display("FAIL to_done got dv/de/rq=%b rdata=%h want 111 deadbeef",
                {bus.done_valid_o, bus.done_err_o, bus.req_ready_o}, bus.done_rdata_o);
        end
        tick(); tick(); tick();                    // cycle 21
        bus.icb_rsp_valid_i = 1'b1; bus.icb_rsp_rdata_i = 32'h33333333;
        tick();                                    // cycle 22
        bus.icb_rsp_valid_i = 1'b0;
        n_cmp++;
        if ({bus.stray_o, bus.done_valid_o, bus.done_rdata_o} !== {2'b10, 32'hDEADBEEF}) begin
            n_bad++; $display("FAIL to_stray got st/dv=%b rdata=%h want 10 deadbeef",
                {bus.stray_o, bus.done_valid_o}, bus.done_rdata_o);
        end
        tick();                                    // cycle 23
        n_cmp++;
        if (bus.stray_o !== 1'b0) begin
            n_bad++; $display("FAIL to_stray_pulse got=%b want=0", bus.stray_o);
        end
    endtask

    // Slave never accepts the command: counter 0 in cycle 1, 15 in cycle 16,
    // error completion in cycle 17.
    task automatic test_cmd_timeout();
        bus.req_valid_i = 1'b1; bus.req_read_i = 1'b0; bus.req_addr_i = 32'h40;
        tick();                                    // cycle 1
        bus.req_valid_i = 1'b0;
        for (int c = 1; c < 16; c++) tick();       // cycle 16
        n_cmp++;
        if ({bus.icb_cmd_valid_o, bus.done_valid_o} !== 2'b10) begin
            n_bad++; $display("FAIL cto_wait got cv/dv=%b want 10", {bus.icb_cmd_valid_o, bus.done_valid_o});
        end
        tick();                                    // cycle 17
        n_cmp++;
        if ({bus.icb_cmd_valid_o, bus.done_valid_o, bus.done_err_o, bus.req_ready_o} !== 4'b0111) begin
            n_bad++; $display("FAIL cto_done got cv/dv/de/rq=%b want 0111",
                {bus.icb_cmd_valid_o, bus.done_valid_o, bus.done_err_o, bus.req_ready_o});
        end
        tick();
    endtask

    // Response arrives in cycle 17, the same cycle the counter is all-ones.
    task automatic test_rsp_at_limit();
        bus.req_valid_i = 1'b1; bus.req_read_i = 1'b1; bus.req_addr_i = 32'h50;
        bus.icb_cmd_ready_i = 1'b1;
        tick();                                    // cycle 1
        bus.req_valid_i = 1'b0;
        tick();                                    // cycle 2
        bus.icb_cmd_ready_i = 1'b0;
        for (int c = 2; c < 17; c++) tick();       // cycle 17
        bus.icb_rsp_valid_i = 1'b1; bus.icb_rsp_rdata_i = 32'hCAFEF00D;
        tick();                                    // cycle 18
        bus.icb_rsp_valid_i = 1'b0;
        n_cmp++;
        if ({bus.done_valid_o, bus.done_err_o, bus.stray_o, bus.done_rdata_o} !== {3'b100, 32'hCAFEF00D}) begin
            n_bad++; $display("FAIL lim_done got dv/de/st=%b rdata=%h want 100 cafef00d",
                {bus.done_valid_o, bus.done_err_o, bus.stray_o}, bus.done_rdata_o);
        end
        tick();
    endtask

    // Reset asserted mid-cycle while waiting in RSP, then a clean read.
    task automatic test_reset_in_rsp();
        bus.req_valid_i = 1'b1; bus.req_read_i = 1'b1; bus.req_addr_i = 32'h60;
        bus.icb_cmd_ready_i = 1'b1;
        tick();                                    // cycle 1
        bus.req_valid_i = 1'b0;
        tick();                                    // cycle 2: in RSP
        bus.icb_cmd_ready_i = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.icb_cmd_valid_o, bus.done_valid_o, bus.done_err_o, bus.stray_o, bus.req_ready_o,
             bus.done_rdata_o, bus.icb_cmd_addr_o, bus.icb_cmd_read_o} !== {5'b00001, 65'h0}) begin
            n_bad++; $display("FAIL arst got flags=%b rdata=%h addr=%h read=%b want 00001 0 0 0",
                {bus.icb_cmd_valid_o, bus.done_valid_o, bus.done_err_o, bus.stray_o, bus.req_ready_o},
                bus.done_rdata_o, bus.icb_cmd_addr_o, bus.icb_cmd_read_o);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if ({bus.done_valid_o, bus.req_ready_o} !== 2'b01) begin
                n_bad++; $display("FAIL arst_idle%0d got dv/rq=%b want 01", i, {bus.done_valid_o, bus.req_ready_o});
            end
        end
        bus.req_valid_i = 1'b1; bus.req_read_i = 1'b1; bus.req_addr_i = 32'h64;
        bus.icb_cmd_ready_i = 1'b1;
        tick();
        bus.req_valid_i = 1'b0;
        tick();
        bus.icb_cmd_ready_i = 1'b0;
        bus.icb_rsp_valid_i = 1'b1; bus.icb_rsp_rdata_i = 32'h0BADF00D;
        tick();
        bus.icb_rsp_valid_i = 1'b0;
        n_cmp++;
        if ({bus.done_valid_o, bus.done_err_o, bus.done_rdata_o} !== {2'b10, 32'h0BADF00D}) begin
            n_bad++; $display("FAIL arst_read got dv/de=%b rdata=%h want 10 0badf00d",
                {bus.done_valid_o, bus.done_err_o}, bus.done_rdata_o);
        end
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        test_reset();
        test_write();
        test_back_to_back();
        test_stall();
        test_rsp_timeout();
        test_cmd_timeout();
        test_rsp_at_limit();
        test_reset_in_rsp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
